// File: rtl/hbridge_coil_sim.sv
// hbridge_coil_sim: behavioural H-bridge coil current model plus PWM duty meter
// Ports:
//   clk, resetn                      clock and asynchronous active-low reset
//   low_1, high_1, low_2, high_2     bridge gate signals, active high
//   polarity_invert_config           negates the reported current
//   current                          signed modelled coil current
//   pwm                              PWM reference being measured
//   duty                             high-sample count of the last completed window
module hbridge_coil_sim #(
    parameter int DRIVE_STEP      = 4,
    parameter int SLOW_DECAY_STEP = 1,
    parameter int FAST_DECAY_STEP = 8,
    parameter int WINDOW_BITS     = 12
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     low_1,
    input  logic                     high_1,
    input  logic                     low_2,
    input  logic                     high_2,
    input  logic                     polarity_invert_config,
    output logic signed [12:0]       current,
    input  logic                     pwm,
    output logic [WINDOW_BITS:0]     duty
);
    localparam logic signed [13:0] MAX_I = 14'sd4095;
    localparam logic signed [13:0] DRV   = 14'(DRIVE_STEP);
    localparam logic signed [13:0] SLW   = 14'(SLOW_DECAY_STEP);
    localparam logic signed [13:0] FST   = 14'(FAST_DECAY_STEP);

    logic signed [12:0]     i_state_q, i_state_d;
    logic signed [13:0]     ext, nxt;
    logic [WINDOW_BITS-1:0] win_q, win_d;
    logic [WINDOW_BITS:0]   acc_q, acc_d, duty_q, duty_d;
    logic                   shoot, fwd, rev, slow, wrap;

    // Symmetric clamp keeps -4096 unreachable so negation for polarity never overflows.
    function automatic logic signed [13:0] sat(input logic signed [13:0] v);
        return (v > MAX_I) ? MAX_I : (v < -MAX_I) ? -MAX_I : v;
    endfunction

    // Step toward zero, landing exactly on zero instead of crossing it.
    function automatic logic signed [13:0] decay(input logic signed [13:0] v, input logic signed [13:0] s);
        logic signed [13:0] mag;
        mag = (v < 0) ? -v : v;
        return (mag < s) ? 14'sd0 : (v < 0) ? v + s : v - s;
    endfunction

    always_comb begin
        ext       = {i_state_q[12], i_state_q};
        shoot     = (high_1 & low_1) | (high_2 & low_2);
        fwd       = high_1 & low_2;
        rev       = high_2 & low_1;
        slow      = (low_1 & low_2) | (high_1 & high_2);
        nxt       = shoot ? ext :
                    fwd   ? sat(ext + DRV) :
                    rev   ? sat(ext - DRV) :
                    slow  ? decay(ext, SLW) : decay(ext, FST);
        i_state_d = nxt[12:0];
        wrap      = &win_q;
        win_d     = win_q + 1'b1;
        acc_d     = wrap ? '0 : acc_q + {{WINDOW_BITS{1'b0}}, pwm};
        duty_d    = wrap ? acc_q + {{WINDOW_BITS{1'b0}}, pwm} : duty_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_state_q <= '0;
            win_q     <= '0;
            acc_q     <= '0;
            duty_q    <= '0;
        end else begin
            i_state_q <= i_state_d;
            win_q     <= win_d;
            acc_q     <= acc_d;
            duty_q    <= duty_d;
        end
    end

    assign current = polarity_invert_config ? -i_state_q : i_state_q;
    assign duty    = duty_q;
endmodule

// File: tb/tb_hbridge_coil_sim.sv
// tb_hbridge_coil_sim: directed bench for the coil current model and duty meter
module tb_hbridge_coil_sim;
    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               low_1 = 1'b0, high_1 = 1'b0, low_2 = 1'b0, high_2 = 1'b0;
    logic               polarity_invert_config = 1'b0;
    logic               pwm = 1'b0;
    logic signed [12:0] current;
    logic [12:0]        duty;
    int                 passed = 0;
    int                 total = 0;

    hbridge_coil_sim dut (
        .clk(clk), .resetn(resetn),
        .low_1(low_1), .high_1(high_1), .low_2(low_2), .high_2(high_2),
        .polarity_invert_config(polarity_invert_config),
        .current(current), .pwm(pwm), .duty(duty)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gates(input logic h1, input logic l1, input logic h2, input logic l2);
        high_1 = h1; low_1 = l1; high_2 = h2; low_2 = l2;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        tick(3);
        check("reset_current", current, 0);
        check("reset_duty", {19'd0, duty}, 0);
        resetn = 1'b1;
        gates(1, 0, 0, 1);
        tick(100);
        check("fwd_100", current, 400);
        polarity_invert_config = 1'b1;
        #1;
        check("invert_neg", current, -400);
        polarity_invert_config = 1'b0;
        #1;
        check("invert_restore", current, 400);
        gates(0, 0, 0, 0);
        tick(50);
        check("fast_to_zero", current, 0);
        tick(10);
        check("fast_stay_zero", current, 0);
        gates(1, 0, 0, 1);
        tick(2);
        gates(0, 1, 0, 1);
        tick(3);
        check("slow_to_5", current, 5);
        gates(0, 0, 0, 0);
        tick(1);
        check("fast_no_overshoot", current, 0);
        gates(1, 0, 0, 1);
        tick(100);
        gates(1, 1, 0, 0);
        tick(20);
        check("shoot_leg1", current, 400);
        gates(1, 1, 1, 1);
        tick(5);
        check("shoot_all", current, 400);
        gates(1, 0, 0, 0);
        tick(1);
        check("single_gate_fast", current, 392);
        gates(1, 0, 1, 0);
        tick(2);
        check("high_side_slow", current, 390);
        gates(1, 0, 0, 1);
        tick(1100);
        check("sat_pos", current, 4095);
        gates(0, 1, 1, 0);
        tick(2048);
        check("sat_neg", current, -4095);
        gates(0, 1, 0, 1);
        tick(95);
        check("slow_neg", current, -4000);
        gates(0, 0, 0, 0);
        tick(1);
        check("fast_neg", current, -3992);
        polarity_invert_config = 1'b1;
        #1;
        check("invert_neg_state", current, 3992);
        polarity_invert_config = 1'b0;
        resetn = 1'b0;
        #1;
        check("async_reset_current", current, 0);
        check("async_reset_duty", {19'd0, duty}, 0);
        tick(2);
        resetn = 1'b1;
        for (int k = 0; k < 4095; k++) begin
            pwm = (k % 4 == 0);
            tick(1);
        end
        check("duty_before_window", {19'd0, duty}, 0);
        pwm = 1'b0;
        tick(1);
        check("duty_quarter_1", {19'd0, duty}, 1024);
        for (int k = 0; k < 4096; k++) begin
            pwm = (k % 4 == 1);
            tick(1);
            if (k == 2000) check("duty_hold", {19'd0, duty}, 1024);
        end
        check("duty_quarter_2", {19'd0, duty}, 1024);
        pwm = 1'b1;
        tick(4096);
        check("duty_full", {19'd0, duty}, 4096);
        pwm = 1'b0;
        tick(4096);
        check("duty_zero", {19'd0, duty}, 0);
        pwm = 1'b1;
        tick(2000);
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        tick(4095);
        check("duty_restart_pending", {19'd0, duty}, 0);
        tick(1);
        check("duty_restart_full", {19'd0, duty}, 4096);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
